// File: rtl/slug_port_peer.sv
// Device-side peer of the slug CPU I/O port: toggle handshake command decoder bridging to TX/RX byte FIFOs.
// Optional macro SLUG_PORT_PEER_LOOPBACK_EN enables command 5 (LOOP: TX head -> RX FIFO).
module slug_port_peer #(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [31:0] port_out,
  output logic [31:0] port_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_TX_PUSH = 3'd1;
  localparam logic [2:0] CMD_RX_POP  = 3'd2;
  localparam logic [2:0] CMD_CLR     = 3'd3;
`ifdef SLUG_PORT_PEER_LOOPBACK_EN
  localparam logic [2:0] CMD_LOOP    = 3'd5;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WAIT, ST_ACK} state_e;

  // Sampling pipeline: only the request toggle, command and write data are carried.
  logic [11:0] sync_q [SYNC_STAGES];
  logic        s_req_tgl;
  logic [2:0]  s_cmd;
  logic [7:0]  s_wdata;
  logic        unused_port_bits;

  assign unused_port_bits = ^port_out[27:8];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {port_out[31:28], port_out[7:0]};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_req_tgl = sync_q[SYNC_STAGES-1][11];
  assign s_cmd     = sync_q[SYNC_STAGES-1][10:8];
  assign s_wdata   = sync_q[SYNC_STAGES-1][7:0];

  state_e        state_q, state_d;
  logic [2:0]    cmd_q;
  logic [7:0]    wdata_q;
  logic          ack_tgl_q;
  logic          err_q;
  logic [7:0]    rdata_q;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CW-1:0] tx_count_q, rx_count_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic loop_exec;
  logic cpu_tx_push, cpu_rx_pop, rx_underflow, clr, set_err, loop_mv, ack_flip, latch_cmd;
  logic tx_host_pop, rx_host_push, tx_push, tx_pop, rx_push, rx_pop, tx_space;

  assign tx_full  = (tx_count_q == CW'(DEPTH));
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == CW'(DEPTH));
  assign rx_empty = (rx_count_q == '0);

`ifdef SLUG_PORT_PEER_LOOPBACK_EN
  // The host is fenced off both FIFOs during LOOP so each side sees one mover per cycle.
  assign loop_exec = (state_q == ST_EXEC) && (cmd_q == CMD_LOOP);
`else
  assign loop_exec = 1'b0;
`endif

  assign tx_valid = !tx_empty && !loop_exec;
  assign rx_ready = !rx_full && !loop_exec;
  assign tx_data  = tx_mem[tx_rd_q];

  // CLR beats any host transfer landing in the same cycle.
  assign tx_host_pop  = tx_valid && tx_ready && !clr;
  assign rx_host_push = rx_valid && rx_ready && !clr;
  assign tx_space     = !tx_full || tx_host_pop;

  assign tx_push = cpu_tx_push;
  assign tx_pop  = tx_host_pop || loop_mv;
  assign rx_push = rx_host_push || loop_mv;
  assign rx_pop  = cpu_rx_pop;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cpu_tx_push  = 1'b0;
    cpu_rx_pop   = 1'b0;
    rx_underflow = 1'b0;
    clr          = 1'b0;
    set_err      = 1'b0;
    loop_mv      = 1'b0;
    ack_flip     = 1'b0;
    latch_cmd    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_req_tgl != ack_tgl_q) begin
          latch_cmd = 1'b1;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_ACK;
        case (cmd_q)
          CMD_NOP: ;
          CMD_TX_PUSH: begin
            if (tx_full) state_d = ST_WAIT;
            else         cpu_tx_push = 1'b1;
          end
          CMD_RX_POP: begin
            if (rx_empty) begin
              rx_underflow = 1'b1;
              set_err      = 1'b1;
            end else begin
              cpu_rx_pop = 1'b1;
            end
          end
          CMD_CLR: clr = 1'b1;
`ifdef SLUG_PORT_PEER_LOOPBACK_EN
          CMD_LOOP: begin
            if (tx_empty || rx_full) set_err = 1'b1;
            else                     loop_mv = 1'b1;
          end
`endif
          default: set_err = 1'b1;
        endcase
      end
      ST_WAIT: begin
        if (tx_space) begin
          cpu_tx_push = 1'b1;
          state_d     = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_flip = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      wdata_q   <= '0;
      ack_tgl_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_cmd) begin
        cmd_q   <= s_cmd;
        wdata_q <= s_wdata;
      end
      if (ack_flip) ack_tgl_q <= ~ack_tgl_q;
      if (clr)          err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;
      if (clr || rx_underflow) rdata_q <= '0;
      else if (cpu_rx_pop)     rdata_q <= rx_mem[rx_rd_q];
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_count_q <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_count_q <= '0;
    end else if (clr) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_count_q <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_count_q <= '0;
    end else begin
      tx_wr_q    <= tx_wr_q + AW'(tx_push);
      tx_rd_q    <= tx_rd_q + AW'(tx_pop);
      tx_count_q <= tx_count_q + CW'(tx_push) - CW'(tx_pop);
      rx_wr_q    <= rx_wr_q + AW'(rx_push);
      rx_rd_q    <= rx_rd_q + AW'(rx_pop);
      rx_count_q <= rx_count_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and counts alone define which entries are valid.
  always_ff @(posedge pclk) begin
    if (tx_push) tx_mem[tx_wr_q] <= wdata_q;
    if (loop_mv)           rx_mem[rx_wr_q] <= tx_mem[tx_rd_q];
    else if (rx_host_push) rx_mem[rx_wr_q] <= rx_data;
  end

  assign port_in = {ack_tgl_q, !rx_empty, tx_full, err_q, 4'b0000,
                    8'(tx_count_q), 8'(rx_count_q), rdata_q};

endmodule

// File: tb/tb_slug_port_peer.sv
// Self-checking bench for slug_port_peer: directed scenarios plus randomized traffic against a queue-based model.
module tb_slug_port_peer;

  localparam int DEPTH     = 16;
  localparam int SYNC      = 2;
  localparam int ACK_BOUND = 60;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic [31:0] port_out = '0;
  logic [31:0] port_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data  = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  slug_port_peer #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .pclk     (pclk),
    .rst      (rst),
    .port_out (port_out),
    .port_in  (port_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  // Reference model: byte queues plus the architectural status registers.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_err   = 1'b0;
  logic       m_ack   = 1'b0;
  logic [7:0] m_rdata = '0;
  logic       req     = 1'b0;

  task automatic cycle();
    @(posedge pclk);
    #1;
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_err   = 1'b0;
    m_ack   = 1'b0;
    m_rdata = '0;
  endtask

  function automatic logic [31:0] exp_port_in();
    return {m_ack, rx_q.size() != 0, tx_q.size() == DEPTH, m_err, 4'b0000,
            8'(tx_q.size()), 8'(rx_q.size()), m_rdata};
  endfunction

  task automatic issue(input logic [2:0] cmd, input logic [7:0] wd);
    req      = ~req;
    port_out = {req, cmd, 20'($urandom), wd};
  endtask

  task automatic wait_ack(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < ACK_BOUND) begin
      cycle();
      n++;
      if (port_in[31] === req) ok = 1'b1;
    end
  endtask

  task automatic model_apply(input logic [2:0] cmd, input logic [7:0] wd);
    m_ack = ~m_ack;
    case (cmd)
      3'd0: ;
      3'd1: tx_q.push_back(wd);
      3'd2: begin
        if (rx_q.size() == 0) begin
          m_rdata = 8'h00;
          m_err   = 1'b1;
        end else begin
          m_rdata = rx_q.pop_front();
        end
      end
      3'd3: begin
        tx_q.delete();
        rx_q.delete();
        m_err   = 1'b0;
        m_rdata = 8'h00;
      end
`ifdef SLUG_PORT_PEER_LOOPBACK_EN
      3'd5: begin
        if (tx_q.size() == 0 || rx_q.size() == DEPTH) m_err = 1'b1;
        else rx_q.push_back(tx_q.pop_front());
      end
`endif
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic cpu_cmd(input logic [2:0] cmd, input logic [7:0] wd, output bit ok);
    int n;
    issue(cmd, wd);
    wait_ack(n, ok);
    if (ok) model_apply(cmd, wd);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cycle();
    checks++;
    if (port_in !== 32'h0) begin
      errors++;
      $display("FAIL reset_port_in: got %h want %h", port_in, 32'h0);
    end
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: tx_valid=%b rx_ready=%b want 0/1", tx_valid, rx_ready);
    end
    rst = 1'b1;
    cycle();
    model_reset();
    checks++;
    if (port_in !== exp_port_in()) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", port_in, exp_port_in());
    end
  endtask

  task automatic test_tx_push();
    int n;
    bit ok;
    issue(3'd1, 8'hA5);
    wait_ack(n, ok);
    checks++;
    if (!ok || n != SYNC + 3) begin
      errors++;
      $display("FAIL tx_push_latency: ack after %0d cycles (acked=%0b) want %0d", n, ok, SYNC + 3);
    end
    if (ok) model_apply(3'd1, 8'hA5);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL tx_push_head: tx_valid=%b tx_data=%h want 1/a5", tx_valid, tx_data);
    end
    checks++;
    if (port_in !== exp_port_in()) begin
      errors++;
      $display("FAIL tx_push_status: got %h want %h", port_in, exp_port_in());
    end
  endtask

  task automatic test_rx_pop();
    bit ok;
    rx_data  = 8'h3C;
    rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
    rx_q.push_back(8'h3C);
    checks++;
    if (port_in !== exp_port_in()) begin
      errors++;
      $display("FAIL rx_host_push: got %h want %h", port_in, exp_port_in());
    end
    cpu_cmd(3'd2, 8'h00, ok);
    checks++;
    if (!ok || port_in[7:0] !== 8'h3C || port_in[30] !== 1'b0 || port_in[28] !== 1'b0) begin
      errors++;
      $display("FAIL rx_pop_data: acked=%0b port_in=%h want rdata 3c rx_avail 0 err 0", ok, port_in);
    end
    checks++;
    if (port_in !== exp_port_in()) begin
      errors++;
      $display("FAIL rx_pop_status: got %h want %h", port_in, exp_port_in());
    end
  endtask

  task automatic test_err_clr();
    bit ok;
    cpu_cmd(3'd2, 8'h00, ok);
    checks++;
    if (!ok || port_in[7:0] !== 8'h00 || port_in[28] !== 1'b1) begin
      errors++;
      $display("FAIL rx_pop_empty: acked=%0b port_in=%h want rdata 00 err 1", ok, port_in);
    end
    cpu_cmd(3'd6, 8'h00, ok);
    checks++;
    if (!ok || port_in !== exp_port_in()) begin
      errors++;
      $display("FAIL reserved_cmd: acked=%0b got %h want %h", ok, port_in, exp_port_in());
    end
    cpu_cmd(3'd3, 8'h00, ok);
    checks++;
    if (!ok || port_in[28] !== 1'b0 || port_in[23:16] !== 8'd0 || port_in[15:8] !== 8'd0) begin
      errors++;
      $display("FAIL clr: acked=%0b port_in=%h want err 0 levels 0", ok, port_in);
    end
    checks++;
    if (port_in !== exp_port_in()) begin
      errors++;
      $display("FAIL clr_status: got %h want %h", port_in, exp_port_in());
    end
  endtask

  task automatic test_tx_full();
    bit ok;
    bit all_ok;
    int n;
    tx_ready = 1'b0;
    all_ok   = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_cmd(3'd1, 8'($urandom), ok);
      all_ok &= ok;
    end
    checks++;
    if (!all_ok || port_in !== exp_port_in() || port_in[29] !== 1'b1) begin
      errors++;
      $display("FAIL tx_fill: acked=%0b got %h want %h", all_ok, port_in, exp_port_in());
    end
    issue(3'd1, 8'hEE);
    repeat (20) cycle();
    checks++;
    if (port_in !== exp_port_in()) begin
      errors++;
      $display("FAIL tx_full_withheld: got %h want %h", port_in, exp_port_in());
    end
    checks++;
    if (tx_data !== tx_q[0]) begin
      errors++;
      $display("FAIL tx_full_head: got %h want %h", tx_data, tx_q[0]);
    end
    tx_ready = 1'b1;
    cycle();
    tx_ready = 1'b0;
    void'(tx_q.pop_front());
    wait_ack(n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tx_wait_ack: no ack within %0d cycles", ACK_BOUND);
    end else begin
      model_apply(3'd1, 8'hEE);
    end
    checks++;
    if (port_in !== exp_port_in() || tx_data !== tx_q[0]) begin
      errors++;
      $display("FAIL tx_wait_push: port_in=%h tx_data=%h want %h / %h",
               port_in, tx_data, exp_port_in(), tx_q[0]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit ok;
    issue(3'd1, 8'h5A);
    repeat (10) cycle();
    checks++;
    if (port_in !== exp_port_in()) begin
      errors++;
      $display("FAIL wait_before_reset: got %h want %h", port_in, exp_port_in());
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (port_in !== 32'h0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: port_in=%h tx_valid=%b rx_ready=%b want 0/0/1", port_in, tx_valid, rx_ready);
    end
    req      = 1'b1;
    port_out = {1'b1, 3'd1, 20'h0, 8'h77};
    repeat (3) cycle();
    checks++;
    if (port_in !== 32'h0) begin
      errors++;
      $display("FAIL held_reset: got %h want %h", port_in, 32'h0);
    end
    rst = 1'b1;
    wait_ack(n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pending_after_reset: no ack within %0d cycles", ACK_BOUND);
    end else begin
      model_apply(3'd1, 8'h77);
    end
    checks++;
    if (port_in !== exp_port_in() || tx_data !== 8'h77) begin
      errors++;
      $display("FAIL post_reset_push: port_in=%h tx_data=%h want %h / 77", port_in, tx_data, exp_port_in());
    end
  endtask

  task automatic test_loop();
    bit ok;
    bit all_ok;
    all_ok = 1'b1;
    cpu_cmd(3'd3, 8'h00, ok);
    all_ok &= ok;
    cpu_cmd(3'd1, 8'h11, ok);
    all_ok &= ok;
    cpu_cmd(3'd5, 8'h00, ok);
    all_ok &= ok;
    checks++;
    if (!all_ok || port_in !== exp_port_in()) begin
      errors++;
      $display("FAIL loop_status: acked=%0b got %h want %h", all_ok, port_in, exp_port_in());
    end
`ifdef SLUG_PORT_PEER_LOOPBACK_EN
    cpu_cmd(3'd2, 8'h00, ok);
    checks++;
    if (!ok || port_in[7:0] !== 8'h11 || port_in[23:16] !== 8'd0 || port_in[28] !== 1'b0) begin
      errors++;
      $display("FAIL loop_data: acked=%0b port_in=%h want rdata 11 tx_level 0 err 0", ok, port_in);
    end
`else
    checks++;
    if (port_in[28] !== 1'b1) begin
      errors++;
      $display("FAIL loop_reserved: err=%b want 1", port_in[28]);
    end
`endif
    cpu_cmd(3'd3, 8'h00, ok);
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        int r;
        logic [2:0] cmd;
        r = $urandom_range(0, 15);
        if (r <= 5)       cmd = 3'd1;
        else if (r <= 9)  cmd = 3'd2;
        else if (r == 10) cmd = 3'd3;
        else if (r == 11) cmd = 3'd0;
        else              cmd = 3'($urandom_range(4, 7));
        if (cmd == 3'd1 && tx_q.size() == DEPTH) cmd = 3'd2;
        cpu_cmd(cmd, 8'($urandom), ok);
        checks++;
        if (!ok || port_in !== exp_port_in()) begin
          errors++;
          $display("FAIL rand_cmd%0d it=%0d: acked=%0b got %h want %h", cmd, it, ok, port_in, exp_port_in());
        end
      end else if (op <= 7) begin
        checks++;
        if (tx_valid !== (tx_q.size() != 0) || (tx_q.size() != 0 && tx_data !== tx_q[0])) begin
          errors++;
          $display("FAIL rand_tx_head it=%0d: tx_valid=%b tx_data=%h want %0b / %h",
                   it, tx_valid, tx_data, tx_q.size() != 0, (tx_q.size() != 0) ? tx_q[0] : 8'h00);
        end
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        if (tx_q.size() != 0) void'(tx_q.pop_front());
      end else begin
        logic [7:0] b;
        b = 8'($urandom);
        checks++;
        if (rx_ready !== (rx_q.size() < DEPTH)) begin
          errors++;
          $display("FAIL rand_rx_ready it=%0d: got %b want %0b", it, rx_ready, rx_q.size() < DEPTH);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        cycle();
        rx_valid = 1'b0;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        checks++;
        if (port_in !== exp_port_in()) begin
          errors++;
          $display("FAIL rand_rx_push it=%0d: got %h want %h", it, port_in, exp_port_in());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_push();
    test_rx_pop();
    test_err_clr();
    test_tx_full();
    test_reset_mid_wait();
    test_loop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slug_port_peer.md
Name: slug_port_peer

Overview:
- Device-side peer of the slug CPU's 32-bit I/O port: decodes command words the CPU drives on port_out and answers on port_in.
- Bridges the CPU to a byte-stream host interface (UART shim, testbench console) through a TX FIFO and an RX FIFO.
- Uses a toggle-based request/acknowledge handshake, so the CPU's multi-phase clocking needs no shared strobe timing.
- Sits beside slug in slug_sim and the FPGA top, clocked from the PLL pclk output.

Parameters:
- DEPTH, 16, entries per FIFO (TX and RX); power of 2, at least 2.
- SYNC_STAGES, 2, flop stages sampling port_out before decode; at least 1.

Ports:
- pclk  input  1  clock (PLL CLKOUT0 domain).
- rst  input  1  asynchronous active-low reset.
- port_out  input  32  command word from CPU: [31] req_tgl, [30:28] cmd, [7:0] wdata; [27:8] ignored.
- port_in  output  32  status word to CPU: [31] ack_tgl, [30] rx_avail, [29] tx_full, [28] err, [23:16] tx_level, [15:8] rx_level, [7:0] rdata; others 0.
- tx_data  output  8  head of TX FIFO.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  host accepts tx_data when tx_valid && tx_ready.
- rx_data  input  8  byte from host.
- rx_valid  input  1  host offers rx_data.
- rx_ready  output  1  RX FIFO not full.

Behaviour:
- Reset (rst low, async): both FIFOs empty; port_in = 0; tx_valid = 0; rx_ready = 1; FSM in IDLE.
- port_out passes through SYNC_STAGES flops; the decoder sees only the last stage (s_*).
- Request pending: s_req_tgl != ack_tgl while in IDLE.
- Commands (cmd):
  - 0 NOP.
  - 1 TX_PUSH: write s_wdata to the TX FIFO.
  - 2 RX_POP: pop the RX FIFO into rdata.
  - 3 CLR: flush both FIFOs, clear err, rdata = 0.
  - 4–7 reserved: set err, no other effect.
- FSM:
  - IDLE: pending → EXEC. cmd is latched in the cycle of the IDLE→EXEC transition.
  - EXEC: perform the command.
    - TX_PUSH with TX FIFO full → WAIT.
    - All other cases → ACK.
  - WAIT: stay until the TX FIFO has space, then push → ACK. A host pop and this push in the same cycle is legal.
  - ACK: ack_tgl <= ~ack_tgl → IDLE.
- Latency with a non-full FIFO: the ack toggle becomes visible on port_in 3 pclk cycles after the sampled toggle change. The CPU sees ack after SYNC_STAGES+3 cycles.
- RX_POP on an empty RX FIFO: rdata = 0x00, err set (sticky), still acknowledged.
- rdata holds its value until the next RX_POP or CLR.
- err is sticky; cleared only by CLR or reset.
- Status bits rx_avail, tx_full, tx_level and rx_level are updated every cycle (combinational from registered FIFO state).
- tx_level and rx_level are zero-extended to 8 bits.
- Host side:
  - TX pop when tx_valid && tx_ready.
  - RX push when rx_valid && rx_ready.
  - Both may coincide with CPU pushes and pops on the same FIFO in the same cycle; occupancy stays consistent and the FIFO wraps modulo DEPTH.
- CLR in the same cycle as a host push or pop: CLR wins and that host transfer is dropped. rx_ready still reads 1, so the host must not treat it as accepted; this is documented as acceptable.
- Reset mid-operation returns to the reset state immediately; an in-flight request is never acknowledged.
- After reset release, an immediately pending request is processed, because the CPU's toggle differs from the reset ack_tgl of 0.
- Toggle changes while the FSM is not in IDLE are not lost: they are re-evaluated on return to IDLE.

Optional Feature:
- Macro SLUG_PORT_PEER_LOOPBACK_EN.
- Defined:
  - Command 5 LOOP copies one byte from the TX FIFO head directly into the RX FIFO in EXEC.
  - If the TX FIFO is empty or the RX FIFO is full, err is set and nothing moves.
  - The host-side tx_valid is forced 0 while the FSM is in EXEC for LOOP.
- Not defined: command 5 is reserved (sets err).

Test Plan:
- Reset, then CPU TX_PUSH 0xA5 (toggle 0→1) → tx_valid = 1, tx_data = 0xA5, port_in[31] = 1 at SYNC_STAGES+3 cycles, tx_level = 1.
- Host drives rx_data 0x3C with rx_valid; CPU RX_POP → port_in[7:0] = 0x3C, rx_avail = 0, err = 0.
- With tx_ready = 0, push 16 bytes, then a 17th → tx_full = 1 and the 17th ack is withheld. Raise tx_ready for 1 cycle → the 17th is pushed, ack toggles, tx_level = 16, first byte out.
- RX_POP on an empty RX FIFO → rdata = 0x00, err = 1. Then CLR → err = 0, both levels 0.
- Assert rst low mid-WAIT → port_in = 0 asynchronously, FIFOs empty. Release → the pending toggle is serviced.
- With SLUG_PORT_PEER_LOOPBACK_EN: push 0x11, LOOP, RX_POP → rdata = 0x11, tx_level = 0. Without the macro: LOOP → err = 1.
